beam_scan_engine: RTL and testbench

- Parametrised delay-and-sum beam scanner; successor to the fixed 4-mic/37-beam weight block.
- Given one FFT bin, it steers over N_BEAMS look directions. For each beam it sums N_CH channel spectra, each multiplied by a complex delay coefficient.
- It computes |sum|^2 per beam and reports the maximum-power beam and its angle. Per-beam powers are streamed out.
- Sits between the frequency-detect block (start, bin) and the angle display / host readout.

---
 rtl/beam_scan_engine.sv | 217 +++++++++++++++++++++
 tb/tb_beam_scan_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_scan_engine.sv
// rtl/beam_scan_engine.sv - delay-and-sum beam scanner reporting per-beam power and the strongest beam
module beam_scan_engine #(
    parameter int N_CH     = 4,
    parameter int N_BEAMS  = 37,
    parameter int DW       = 14,
    parameter int CW       = 14,
    parameter int BIN_W    = 10,
    parameter int RD_LAT   = 2,
    parameter int ANG_MIN  = -90,
    parameter int ANG_STEP = 5,
    parameter int ANG_W    = 8,
    localparam int CHW     = $clog2(N_CH),
    localparam int BMW     = $clog2(N_BEAMS),
    localparam int CAW     = $clog2(N_BEAMS * N_CH),
    localparam int PW      = DW + CW + 1,
    localparam int AW      = PW + CHW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic [BIN_W-1:0]        fft_addr,
    output logic [CHW-1:0]          fft_ch,
    input  logic [2*DW-1:0]         fft_q,
    output logic [CAW-1:0]          coef_addr,
    input  logic [2*CW-1:0]         coef_q,
    output logic                    busy,
    output logic                    done,
    output logic                    beam_valid,
    output logic [BMW-1:0]          beam_idx,
    output logic [2*AW-1:0]         beam_pwr,
    output logic [BMW-1:0]          best_beam,
    output logic signed [ANG_W-1:0] best_angle,
    output logic [2*AW-1:0]         best_pwr
);

    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        ACC  = 3'd2,
        PWR  = 3'd3,
        CMP  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [BMW-1:0]         beam_q, beam_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic [LW-1:0]          lat_q, lat_d;
    logic signed [AW-1:0]   acc_re_q, acc_re_d;
    logic signed [AW-1:0]   acc_im_q, acc_im_d;
    logic [2*AW-1:0]        pwr_q, pwr_d;
    logic [2*AW-1:0]        max_pwr_q, max_pwr_d;
    logic [BMW-1:0]         max_beam_q, max_beam_d;
    logic [BMW-1:0]         best_beam_q, best_beam_d;
    logic [ANG_W-1:0]       best_angle_q, best_angle_d;
    logic [2*AW-1:0]        best_pwr_q, best_pwr_d;

    logic signed [PW-1:0]   fr_x, fi_x, cr_x, ci_x;
    logic signed [PW-1:0]   prod_re, prod_im;
    logic signed [2*AW-1:0] re_x, im_x, sq_re, sq_im;
    logic [ANG_W-1:0]       max_angle;

    // Complex multiply of the current channel sample by its steering coefficient, plus |acc|^2
    always_comb begin
        fr_x    = PW'($signed(fft_q[2*DW-1:DW]));
        fi_x    = PW'($signed(fft_q[DW-1:0]));
        cr_x    = PW'($signed(coef_q[2*CW-1:CW]));
        ci_x    = PW'($signed(coef_q[CW-1:0]));
        prod_re = cr_x * fr_x - ci_x * fi_x;
        prod_im = cr_x * fi_x + ci_x * fr_x;
        re_x    = (2*AW)'(acc_re_q);
        im_x    = (2*AW)'(acc_im_q);
        sq_re   = re_x * re_x;
        sq_im   = im_x * im_x;
    end

    assign max_angle = ANG_W'(ANG_MIN) + ANG_W'(ANG_STEP) * ANG_W'(max_beam_q);

    // Scan sequencer: per beam, RD_LAT address cycles then one accumulate per channel, then power and compare
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        beam_d       = beam_q;
        ch_d         = ch_q;
        lat_d        = lat_q;
        acc_re_d     = acc_re_q;
        acc_im_d     = acc_im_q;
        pwr_d        = pwr_q;
        max_pwr_d    = max_pwr_q;
        max_beam_d   = max_beam_q;
        best_beam_d  = best_beam_q;
        best_angle_d = best_angle_q;
        best_pwr_d   = best_pwr_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ADDR: begin
                if (lat_q == LW'(RD_LAT - 1)) begin
                    lat_d   = '0;
                    state_d = ACC;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ACC: begin
                acc_re_d = acc_re_q + AW'(prod_re);
                acc_im_d = acc_im_q + AW'(prod_im);
                if (ch_q == CHW'(N_CH - 1)) begin
                    state_d = PWR;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    state_d = ADDR;
                end
            end
            PWR: begin
                pwr_d   = sq_re + sq_im;
                state_d = CMP;
            end
            CMP: begin
                // Strict compare: on ties the earlier (lower) beam is kept
                if (pwr_q > max_pwr_q) begin
                    max_pwr_d  = pwr_q;
                    max_beam_d = beam_q;
                end
                if (beam_q == BMW'(N_BEAMS - 1)) begin
                    state_d = DONE;
                end else begin
                    beam_d   = beam_q + BMW'(1);
                    ch_d     = '0;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    state_d  = ADDR;
                end
            end
            DONE: begin
                best_beam_d  = max_beam_q;
                best_angle_d = max_angle;
                best_pwr_d   = max_pwr_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start in any state (including DONE) begins a fresh scan; reported best values are untouched
        if (start) begin
            bin_d      = bin;
            beam_d     = '0;
            ch_d       = '0;
            lat_d      = '0;
            acc_re_d   = '0;
            acc_im_d   = '0;
            pwr_d      = '0;
            max_pwr_d  = '0;
            max_beam_d = '0;
            state_d    = ADDR;
        end
    end

    // State and datapath registers; reset wins over start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            beam_q       <= '0;
            ch_q         <= '0;
            lat_q        <= '0;
            acc_re_q     <= '0;
            acc_im_q     <= '0;
            pwr_q        <= '0;
            max_pwr_q    <= '0;
            max_beam_q   <= '0;
            best_beam_q  <= '0;
            best_angle_q <= '0;
            best_pwr_q   <= '0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            beam_q       <= beam_d;
            ch_q         <= ch_d;
            lat_q        <= lat_d;
            acc_re_q     <= acc_re_d;
            acc_im_q     <= acc_im_d;
            pwr_q        <= pwr_d;
            max_pwr_q    <= max_pwr_d;
            max_beam_q   <= max_beam_d;
            best_beam_q  <= best_beam_d;
            best_angle_q <= best_angle_d;
            best_pwr_q   <= best_pwr_d;
        end
    end

    // Memory addressing follows the counters directly
    assign fft_addr  = bin_q;
    assign fft_ch    = ch_q;
    assign coef_addr = CAW'(beam_q) * CAW'(N_CH) + CAW'(ch_q);

    // Status and per-beam result strobes
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign beam_valid = (state_q == CMP);
    assign beam_idx   = (state_q == CMP) ? beam_q : '0;
    assign beam_pwr   = (state_q == CMP) ? pwr_q  : '0;

    // During DONE the final max registers are shown so best_* is valid alongside the done pulse
    assign best_beam  = done ? max_beam_q : best_beam_q;
    assign best_angle = done ? max_angle  : best_angle_q;
    assign best_pwr   = done ? max_pwr_q  : best_pwr_q;

endmodule

// File: tb/tb_beam_scan_engine.sv
// tb/tb_beam_scan_engine.sv - scoreboard bench for beam_scan_engine at default and swept parameters
module tb_beam_scan_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int     idx;
        longint pwr;
    } exp_t;

    // ---------------- instance A: default parameters ----------------
    logic              a_start;
    logic [9:0]        a_bin, a_fft_addr;
    logic [1:0]        a_fft_ch;
    logic [27:0]       a_fft_q, a_coef_q;
    logic [7:0]        a_coef_addr;
    logic              a_busy, a_done, a_beam_valid;
    logic [5:0]        a_beam_idx, a_best_beam;
    logic [61:0]       a_beam_pwr, a_best_pwr;
    logic signed [7:0] a_best_angle;

    beam_scan_engine u_a (
        .clk(clk), .reset(reset), .start(a_start), .bin(a_bin),
        .fft_addr(a_fft_addr), .fft_ch(a_fft_ch), .fft_q(a_fft_q),
        .coef_addr(a_coef_addr), .coef_q(a_coef_q),
        .busy(a_busy), .done(a_done), .beam_valid(a_beam_valid),
        .beam_idx(a_beam_idx), .beam_pwr(a_beam_pwr),
        .best_beam(a_best_beam), .best_angle(a_best_angle), .best_pwr(a_best_pwr)
    );

    int fa_re[4], fa_im[4], ca_re[148], ca_im[148];
    logic [27:0] a_fpipe[2], a_cpipe[2];
    always @(posedge clk) begin
        a_fpipe[0] <= {14'(fa_re[a_fft_ch]), 14'(fa_im[a_fft_ch])};
        a_fpipe[1] <= a_fpipe[0];
        a_cpipe[0] <= {14'(ca_re[a_coef_addr]), 14'(ca_im[a_coef_addr])};
        a_cpipe[1] <= a_cpipe[0];
    end
    assign a_fft_q  = a_fpipe[1];
    assign a_coef_q = a_cpipe[1];

    exp_t qa[$];
    int   dqa[$];
    int   exp_bin_a = 0;

    always @(posedge clk) begin
        if (reset) exp_bin_a <= 0;
        else if (a_start) exp_bin_a <= int'(a_bin);
    end

    function automatic longint model_a(input int beam);
        longint re = 0, im = 0;
        for (int ch = 0; ch < 4; ch++) begin
            longint cr = ca_re[beam*4+ch], ci = ca_im[beam*4+ch];
            longint fr = fa_re[ch], fi = fa_im[ch];
            re += cr * fr - ci * fi;
            im += cr * fi + ci * fr;
        end
        return re * re + im * im;
    endfunction

    task automatic push_a(input int first, input int last);
        for (int b = first; b <= last; b++) begin
            exp_t e;
            e.idx = b;
            e.pwr = model_a(b);
            qa.push_back(e);
        end
    endtask

    task automatic set_a(input int beam, input int cre, input int cim, input int fre, input int fim);
        for (int i = 0; i < 148; i++) begin
            ca_re[i] = (i / 4 == beam) ? cre : 0;
            ca_im[i] = (i / 4 == beam) ? cim : 0;
        end
        for (int c = 0; c < 4; c++) begin
            fa_re[c] = fre;
            fa_im[c] = fim;
        end
    endtask

    // Monitor A: beam results, done timing and fft address while busy
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_beam_valid) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_extra_beam actual idx=%0d expected=none", a_beam_idx);
            end else begin
                e = qa.pop_front();
                chk("a_beam_idx", longint'(a_beam_idx), longint'(e.idx));
                chk("a_beam_pwr", longint'(a_beam_pwr), e.pwr);
            end
        end
        if (a_done) begin
            if (dqa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_extra_done actual cycle=%0d expected=none", cyc);
            end else begin
                chk("a_done_cycle", longint'(cyc), longint'(dqa.pop_front()));
            end
        end
        if (a_busy) chk("a_fft_addr", longint'(a_fft_addr), longint'(exp_bin_a));
    end

    task automatic go_a(input int b, input bit expect_done, output int t);
        a_start = 1'b1;
        a_bin   = 10'(b);
        t       = cyc;
        if (expect_done) dqa.push_back(cyc + 519);
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a();
        int n = 0;
        while ((dqa.size() != 0 || qa.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL a_timeout actual pending=%0d expected=0", dqa.size() + qa.size());
        end
        @(negedge clk);
    endtask

    task automatic best_a(input string nm, input int bb, input int ba, input longint bp);
        chk({nm, "_best_beam"}, longint'(a_best_beam), longint'(bb));
        chk({nm, "_best_angle"}, longint'(a_best_angle), longint'(ba));
        chk({nm, "_best_pwr"}, longint'(a_best_pwr), bp);
        chk({nm, "_busy_after"}, longint'(a_busy), 0);
    endtask

    task automatic zero_a(input string nm);
        chk({nm, "_busy"}, longint'(a_busy), 0);
        chk({nm, "_done"}, longint'(a_done), 0);
        chk({nm, "_beam_valid"}, longint'(a_beam_valid), 0);
        chk({nm, "_beam_idx"}, longint'(a_beam_idx), 0);
        chk({nm, "_beam_pwr"}, longint'(a_beam_pwr), 0);
        chk({nm, "_best_beam"}, longint'(a_best_beam), 0);
        chk({nm, "_best_angle"}, longint'(a_best_angle), 0);
        chk({nm, "_best_pwr"}, longint'(a_best_pwr), 0);
        chk({nm, "_fft_addr"}, longint'(a_fft_addr), 0);
        chk({nm, "_fft_ch"}, longint'(a_fft_ch), 0);
        chk({nm, "_coef_addr"}, longint'(a_coef_addr), 0);
    endtask

    // ---------------- instance B: N_CH=8, N_BEAMS=19, RD_LAT=1, ANG_STEP=10 ----------------
    logic              b_start;
    logic [9:0]        b_bin, b_fft_addr;
    logic [2:0]        b_fft_ch;
    logic [27:0]       b_fft_q, b_coef_q;
    logic [7:0]        b_coef_addr;
    logic              b_busy, b_done, b_beam_valid;
    logic [4:0]        b_beam_idx, b_best_beam;
    logic [63:0]       b_beam_pwr, b_best_pwr;
    logic signed [7:0] b_best_angle;

    beam_scan_engine #(.N_CH(8), .N_BEAMS(19), .RD_LAT(1), .ANG_STEP(10)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .bin(b_bin),
        .fft_addr(b_fft_addr), .fft_ch(b_fft_ch), .fft_q(b_fft_q),
        .coef_addr(b_coef_addr), .coef_q(b_coef_q),
        .busy(b_busy), .done(b_done), .beam_valid(b_beam_valid),
        .beam_idx(b_beam_idx), .beam_pwr(b_beam_pwr),
        .best_beam(b_best_beam), .best_angle(b_best_angle), .best_pwr(b_best_pwr)
    );

    int cb_re[152];
    logic [27:0] b_fpipe, b_cpipe;
    always @(posedge clk) begin
        b_fpipe <= {14'(100), 14'(0)};
        b_cpipe <= {14'(cb_re[b_coef_addr]), 14'(0)};
    end
    assign b_fft_q  = b_fpipe;
    assign b_coef_q = b_cpipe;

    exp_t qb[$];
    int   dqb[$];
    int   b_last_ca = 0, b_max_ca = 0, b_walk_err = 0;

    // Monitor B: beam results, done timing and the coefficient address walk
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_beam_valid) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_beam actual idx=%0d expected=none", b_beam_idx);
            end else begin
                e = qb.pop_front();
                chk("b_beam_idx", longint'(b_beam_idx), longint'(e.idx));
                chk("b_beam_pwr", longint'(b_beam_pwr), e.pwr);
            end
        end
        if (b_done) begin
            if (dqb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_done actual cycle=%0d expected=none", cyc);
            end else begin
                chk("b_done_cycle", longint'(cyc), longint'(dqb.pop_front()));
            end
        end
        if (b_busy && int'(b_coef_addr) != b_last_ca) begin
            if (int'(b_coef_addr) != b_last_ca + 1) b_walk_err++;
            b_last_ca = int'(b_coef_addr);
            if (b_last_ca > b_max_ca) b_max_ca = b_last_ca;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset   = 1'b1;
        a_start = 1'b0;
        a_bin   = '0;
        b_start = 1'b0;
        b_bin   = '0;
        set_a(10, 1, 0, 100, 0);
        for (int i = 0; i < 152; i++) cb_re[i] = (i >= 144) ? 1 : 0;
        repeat (3) @(negedge clk);
        zero_a("rst");
        chk("rst_b_busy", longint'(b_busy), 0);
        chk("rst_b_best_angle", longint'(b_best_angle), 0);
        reset = 1'b0;
        @(negedge clk);

        // Unit coefficient at beam 10: 4 channels * 100 -> 400^2
        push_a(0, 36);
        chk("t1_model_beam10", model_a(10), 160000);
        go_a(5, 1'b1, t);
        wait_a();
        best_a("t1", 10, -40, 160000);

        // All-zero ROM: nothing beats zero, so beam 0 is kept
        set_a(99, 0, 0, 100, 0);
        push_a(0, 36);
        go_a(5, 1'b1, t);
        wait_a();
        best_a("t2", 0, -90, 0);

        // Extreme magnitudes: acc_re = 2^29 - 2^15, acc_im = 2^15
        set_a(36, -8192, 8191, -8192, -8192);
        push_a(0, 36);
        go_a(12, 1'b1, t);
        wait_a();
        best_a("t3", 36, 90, (longint'(1) << 58) - (longint'(1) << 45) + (longint'(1) << 31));

        // Abort at cycle 100: 7 beams of the first scan, then a full restarted scan
        set_a(10, 1, 0, 100, 0);
        push_a(0, 6);
        go_a(5, 1'b0, t);
        while (cyc != t + 100) @(negedge clk);
        push_a(0, 36);
        go_a(7, 1'b1, t);
        chk("t4_fft_addr_switch", longint'(a_fft_addr), 7);
        wait_a();
        best_a("t4", 10, -40, 160000);

        // Reset at cycle 200: beams 0..13 have reported, then everything clears
        push_a(0, 13);
        go_a(3, 1'b0, t);
        while (cyc != t + 200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        zero_a("t5");
        reset = 1'b0;
        @(negedge clk);
        push_a(0, 36);
        go_a(9, 1'b1, t);
        wait_a();
        best_a("t5_after", 10, -40, 160000);

        // Parameter sweep instance: unit coefficient at beam 18, 8 channels * 100 -> 800^2
        for (int b = 0; b < 19; b++) begin
            exp_t e;
            e.idx = b;
            e.pwr = (b == 18) ? 640000 : 0;
            qb.push_back(e);
        end
        b_start = 1'b1;
        b_bin   = 10'd21;
        dqb.push_back(cyc + 343);
        @(negedge clk);
        b_start = 1'b0;
        chk("t6_fft_addr", longint'(b_fft_addr), 21);
        begin
            int n = 0;
            while ((dqb.size() != 0 || qb.size() != 0) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) begin
                checks++; errors++;
                $display("FAIL b_timeout actual pending=%0d expected=0", dqb.size() + qb.size());
            end
        end
        @(negedge clk);
        chk("t6_best_beam", longint'(b_best_beam), 18);
        chk("t6_best_angle", longint'(b_best_angle), 90);
        chk("t6_best_pwr", longint'(b_best_pwr), 640000);
        chk("t6_coef_walk_steps", longint'(b_walk_err), 0);
        chk("t6_coef_addr_max", longint'(b_max_ca), 151);

        chk("end_qa_empty", longint'(qa.size() + dqa.size()), 0);
        chk("end_qb_empty", longint'(qb.size() + dqb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
